// File: rtl/edge_bbox_detect_if.sv
// Stream and result bundle for edge_bbox_detect.
// Carries the 1-bit Sobel pixel stream with its qualifiers, plus the per-frame results.
// The master drives the stream and observes results; the slave (the detector) does the reverse.
interface edge_bbox_detect_if #(
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 10,
  parameter int CNT_WIDTH = 20
);
  logic                 sobel;
  logic                 sobel_valid;
  logic                 sobel_hsync;
  logic                 sobel_vsync;
  logic [X_WIDTH-1:0]   x_min;
  logic [X_WIDTH-1:0]   x_max;
  logic [Y_WIDTH-1:0]   y_min;
  logic [Y_WIDTH-1:0]   y_max;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 bbox_found;
  logic                 bbox_valid;

  modport master (
    output sobel, sobel_valid, sobel_hsync, sobel_vsync,
    input  x_min, x_max, y_min, y_max, edge_cnt, bbox_found, bbox_valid
  );

  modport slave (
    input  sobel, sobel_valid, sobel_hsync, sobel_vsync,
    output x_min, x_max, y_min, y_max, edge_cnt, bbox_found, bbox_valid
  );
endinterface

// File: rtl/edge_bbox_detect.sv
// Per-frame bounding box and count of Sobel edge pixels, published with a one-cycle strobe.
// Latency: accumulators update 1 cycle after a pixel; results appear 1 cycle after vsync is sampled low.
// No backpressure: the stream is consumed unconditionally. Option macro: EDGE_BBOX_BORDER_MASK_EN.
module edge_bbox_detect #(
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 10,
  parameter int CNT_WIDTH = 20,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter logic [CNT_WIDTH-1:0] MIN_EDGE_CNT = CNT_WIDTH'(16)
) (
  input logic clk,
  input logic rst_p,
  edge_bbox_detect_if.slave bus
);

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMG_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;

  logic hs_d;
  logic vs_d;
  logic line_has_pix;
  logic [X_WIDTH-1:0] x_cnt;
  logic [Y_WIDTH-1:0] y_cnt;

  logic [X_WIDTH-1:0]   acc_xmin;
  logic [X_WIDTH-1:0]   acc_xmax;
  logic [Y_WIDTH-1:0]   acc_ymin;
  logic [Y_WIDTH-1:0]   acc_ymax;
  logic [CNT_WIDTH-1:0] acc_cnt;

  logic hs_fall;
  logic vs_rise;
  logic vs_fall;
  logic pix_step;
  logic [Y_WIDTH-1:0] y_eff;
  logic in_range;
  logic on_border;
  logic accepted;
  logic edge_pix;

  assign hs_fall  = hs_d & ~bus.sobel_hsync;
  assign vs_rise  = bus.sobel_vsync & ~vs_d;
  assign vs_fall  = vs_d & ~bus.sobel_vsync;
  assign pix_step = bus.sobel_valid & bus.sobel_hsync;

  // The row counter is only cleared at the vsync-rise edge, so a pixel arriving in
  // that very cycle must already see row 0 rather than last frame's row count.
  assign y_eff    = vs_rise ? '0 : y_cnt;
  assign in_range = (x_cnt <= X_LAST) && (y_eff <= Y_LAST);

`ifdef EDGE_BBOX_BORDER_MASK_EN
  // Sobel's 3x3 window produces artefacts on the outermost ring; drop it entirely.
  assign on_border = (x_cnt == '0) || (x_cnt == X_LAST) || (y_eff == '0) || (y_eff == Y_LAST);
`else
  assign on_border = 1'b0;
`endif

  assign accepted = pix_step & bus.sobel_vsync & in_range & ~on_border;
  assign edge_pix = accepted & bus.sobel;

  // Previous-cycle sync levels; vs_d starts high so a frame already running at reset release is skipped.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      hs_d <= 1'b0;
      vs_d <= 1'b1;
    end else begin
      hs_d <= bus.sobel_hsync;
      vs_d <= bus.sobel_vsync;
    end
  end

  // Column counter: one step per valid pixel in a line, cleared at line end, saturating.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      x_cnt <= '0;
    end else if (hs_fall) begin
      x_cnt <= '0;
    end else if (pix_step && (x_cnt != '1)) begin
      x_cnt <= x_cnt + X_WIDTH'(1);
    end
  end

  // Row counter: advances at the end of any line that carried a valid pixel, restarts per frame.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      y_cnt        <= '0;
      line_has_pix <= 1'b0;
    end else begin
      if (hs_fall) begin
        line_has_pix <= 1'b0;
      end else if (pix_step) begin
        line_has_pix <= 1'b1;
      end

      if (vs_rise) begin
        y_cnt <= '0;
      end else if (hs_fall && line_has_pix && (y_cnt != '1)) begin
        y_cnt <= y_cnt + Y_WIDTH'(1);
      end
    end
  end

  // Frame FSM: clears accumulators at frame start, folds in edge pixels, publishes at frame end.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state          <= IDLE;
      acc_xmin       <= '0;
      acc_xmax       <= '0;
      acc_ymin       <= '0;
      acc_ymax       <= '0;
      acc_cnt        <= '0;
      bus.x_min      <= '0;
      bus.x_max      <= '0;
      bus.y_min      <= '0;
      bus.y_max      <= '0;
      bus.edge_cnt   <= '0;
      bus.bbox_found <= 1'b0;
      bus.bbox_valid <= 1'b0;
    end else begin
      bus.bbox_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_rise) begin
            state    <= ACTIVE;
            acc_xmin <= edge_pix ? x_cnt : '1;
            acc_xmax <= edge_pix ? x_cnt : '0;
            acc_ymin <= edge_pix ? y_eff : '1;
            acc_ymax <= edge_pix ? y_eff : '0;
            acc_cnt  <= edge_pix ? CNT_WIDTH'(1) : '0;
          end
        end

        ACTIVE: begin
          if (edge_pix) begin
            if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
            if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
            if (y_eff < acc_ymin) acc_ymin <= y_eff;
            if (y_eff > acc_ymax) acc_ymax <= y_eff;
            if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
          end
          // Results are registered on the way into REPORT so they and the strobe
          // are visible during the REPORT cycle itself.
          if (vs_fall) begin
            state          <= REPORT;
            bus.bbox_valid <= 1'b1;
            bus.edge_cnt   <= acc_cnt;
            bus.bbox_found <= (acc_cnt >= MIN_EDGE_CNT);
            if (acc_cnt == '0) begin
              bus.x_min <= '0;
              bus.x_max <= '0;
              bus.y_min <= '0;
              bus.y_max <= '0;
            end else begin
              bus.x_min <= acc_xmin;
              bus.x_max <= acc_xmax;
              bus.y_min <= acc_ymin;
              bus.y_max <= acc_ymax;
            end
          end
        end

        REPORT: begin
          // A vsync rise here is illegal; vs_d will already be high next cycle, so that frame is dropped.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_bbox_detect.sv
// Directed bench for edge_bbox_detect on an 8x4 image with MIN_EDGE_CNT=4.
// Frames are generated line by line; expected boxes and counts are hand-computed constants.
// Mask-dependent expectations follow EDGE_BBOX_BORDER_MASK_EN.
module tb_edge_bbox_detect;

  localparam int XW = 4;
  localparam int YW = 3;
  localparam int CW = 20;

  logic clk = 1'b0;
  logic rst_p;

  int checks = 0;
  int errors = 0;

  edge_bbox_detect_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .CNT_WIDTH(CW)) bus ();

  edge_bbox_detect #(
    .X_WIDTH(XW),
    .Y_WIDTH(YW),
    .CNT_WIDTH(CW),
    .IMG_WIDTH(8),
    .IMG_HEIGHT(4),
    .MIN_EDGE_CNT(20'd4)
  ) dut (
    .clk  (clk),
    .rst_p(rst_p),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: no edges, 1: single edge at (3,2), 2: all edges, 3: edges only outside the 8x4 window
  function automatic bit edge_at(input int mode, input int x, input int y);
    case (mode)
      1: return (x == 3) && (y == 2);
      2: return 1'b1;
      3: return (x >= 8) || (y >= 4);
      default: return 1'b0;
    endcase
  endfunction

  task automatic start_frame;
    bus.sobel_vsync = 1'b1;
    bus.sobel_hsync = 1'b0;
    tick();
  endtask

  task automatic send_lines(input int npix, input int y0, input int nlines, input int mode);
    for (int y = y0; y < y0 + nlines; y++) begin
      for (int x = 0; x < npix; x++) begin
        bus.sobel_hsync = 1'b1;
        bus.sobel_valid = 1'b1;
        bus.sobel       = edge_at(mode, x, y);
        tick();
      end
      bus.sobel_hsync = 1'b0;
      bus.sobel_valid = 1'b0;
      bus.sobel       = 1'b0;
      tick();
    end
  endtask

  // Drops vsync and watches a bounded window for the strobe: first-cycle latency and pulse width.
  task automatic end_frame(output int lat, output int width);
    bus.sobel_vsync = 1'b0;
    lat   = 0;
    width = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus.bbox_valid === 1'b1) begin
        if (lat == 0) lat = i;
        width++;
      end
    end
  endtask

  task automatic check_result(input string tag, input int xmin, input int xmax,
                              input int ymin, input int ymax, input int cnt, input int found);
    check({tag, ".x_min"},      32'(bus.x_min),      xmin);
    check({tag, ".x_max"},      32'(bus.x_max),      xmax);
    check({tag, ".y_min"},      32'(bus.y_min),      ymin);
    check({tag, ".y_max"},      32'(bus.y_max),      ymax);
    check({tag, ".edge_cnt"},   32'(bus.edge_cnt),   cnt);
    check({tag, ".bbox_found"}, 32'(bus.bbox_found), found);
  endtask

  initial begin
    int lat;
    int width;

    // Reset with vsync already high: the partial frame after release must be discarded.
    rst_p           = 1'b1;
    bus.sobel       = 1'b0;
    bus.sobel_valid = 1'b0;
    bus.sobel_hsync = 1'b0;
    bus.sobel_vsync = 1'b1;
    repeat (3) tick();
    check_result("reset", 0, 0, 0, 0, 0, 0);
    check("reset.bbox_valid", 32'(bus.bbox_valid), 0);
    rst_p = 1'b0;
    tick();
    send_lines(8, 0, 4, 2);
    end_frame(lat, width);
    check("partial.strobe", 32'(width), 0);
    check_result("partial", 0, 0, 0, 0, 0, 0);

    // Single edge at (3,2).
    start_frame();
    send_lines(8, 0, 4, 1);
    end_frame(lat, width);
    check("single.latency", 32'(lat), 1);
    check("single.width", 32'(width), 1);
    check_result("single", 3, 3, 2, 2, 1, 0);

    // Empty frame still strobes with all-zero results.
    start_frame();
    send_lines(8, 0, 4, 0);
    end_frame(lat, width);
    check("empty.latency", 32'(lat), 1);
    check("empty.width", 32'(width), 1);
    check_result("empty", 0, 0, 0, 0, 0, 0);

    // 10-pixel lines and 6 lines; edges only beyond the active window.
    start_frame();
    send_lines(10, 0, 6, 3);
    end_frame(lat, width);
    check("oversize.latency", 32'(lat), 1);
    check_result("oversize", 0, 0, 0, 0, 0, 0);

    // Every pixel is an edge.
    start_frame();
    send_lines(8, 0, 4, 2);
    end_frame(lat, width);
    check("full.latency", 32'(lat), 1);
`ifdef EDGE_BBOX_BORDER_MASK_EN
    check_result("full", 1, 6, 1, 2, 12, 1);
`else
    check_result("full", 0, 7, 0, 3, 32, 1);
`endif

    // One-cycle reset in the middle of a frame: outputs clear at once, frame is lost.
    start_frame();
    send_lines(8, 0, 2, 2);
    rst_p = 1'b1;
    #2;
    check("midrst.async_cnt", 32'(bus.edge_cnt), 0);
    check("midrst.async_xmax", 32'(bus.x_max), 0);
    check("midrst.async_found", 32'(bus.bbox_found), 0);
    tick();
    rst_p = 1'b0;
    send_lines(8, 2, 2, 2);
    end_frame(lat, width);
    check("midrst.strobe", 32'(width), 0);
    check("midrst.cnt_after", 32'(bus.edge_cnt), 0);

    // Next full frame after the reset reports normally.
    start_frame();
    send_lines(8, 0, 4, 1);
    end_frame(lat, width);
    check("recover.latency", 32'(lat), 1);
    check("recover.width", 32'(width), 1);
    check_result("recover", 3, 3, 2, 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_bbox_detect.md
# edge_bbox_detect

Frame-level edge statistics stage sitting directly downstream of the image preprocessing top (RGB→gray→median→Sobel). It consumes the 1-bit Sobel stream with its valid/hsync/vsync qualifiers, tracks pixel coordinates, and per frame accumulates the bounding box and count of edge pixels. At frame end it publishes the results with a one-cycle strobe for the target-locating/overlay logic.

## Interface
- IMG_WIDTH, 640, active pixels per line; pixels with x ≥ IMG_WIDTH ignored
- IMG_HEIGHT, 480, active lines per frame; lines with y ≥ IMG_HEIGHT ignored
- X_WIDTH, 11, coordinate width for x (must hold IMG_WIDTH-1)
- Y_WIDTH, 10, coordinate width for y (must hold IMG_HEIGHT-1)
- CNT_WIDTH, 20, edge-pixel counter width
- MIN_EDGE_CNT, 20'd16, minimum edge count for bbox_found
- clk  input  1  pixel-domain clock (same clock as the Sobel stage)
- rst_p  input  1  reset; **one clock; reset is asynchronous and active-high**
- sobel  input  1  binary edge pixel (1 = edge)
- sobel_valid  input  1  pixel qualifier
- sobel_hsync  input  1  line active (high during a line)
- sobel_vsync  input  1  frame active (high during a frame; already inverted upstream)
- x_min, x_max  output  X_WIDTH  bounding box columns of last frame
- y_min, y_max  output  Y_WIDTH  bounding box rows of last frame
- edge_cnt  output  CNT_WIDTH  edge pixels counted in last frame
- bbox_found  output  1  edge_cnt ≥ MIN_EDGE_CNT for last frame
- bbox_valid  output  1  one-cycle strobe: results updated

## Operation
- Accepted pixel: sobel_valid & sobel_hsync & sobel_vsync & x<IMG_WIDTH & y<IMG_HEIGHT (plus border mask, see Configuration). Edge pixel: accepted & sobel.
- x counter: increments per sobel_valid&hsync; cleared on hsync falling edge. y counter: increments on hsync falling edge if the line had ≥1 valid pixel; cleared on vsync rising edge. Both saturate at all-ones, never wrap.
- Edge detection uses registered previous hsync/vsync (hs_d, vs_d). vs_d resets to 1, hs_d to 0.
- FSM states: IDLE, ACTIVE, REPORT.
  - IDLE: vsync rising (vsync=1, vs_d=0) → ACTIVE; accumulators cleared (min to all-ones, max 0, count 0). A pixel in that same cycle is applied on top of the clear values.
  - ACTIVE: update x_min/x_max/y_min/y_max by compare, edge count +1 (saturating at 2^CNT_WIDTH-1) per edge pixel; vsync falling → REPORT.
  - REPORT: copy accumulators to outputs, assert bbox_valid; → IDLE unconditionally.
- Vsync high at reset release: stays IDLE (partial frame discarded) until next rising edge.
- Frame with zero edge pixels: reported x_min=x_max=y_min=y_max=0, edge_cnt=0, bbox_found=0.
- Vsync rising while in REPORT is impossible for legal streams (≥1 blanking cycle); if it occurs it is ignored and that frame is discarded.
- Pixels with vsync low are never counted, including in the falling-edge cycle.

## Timing
- All outputs reset to 0.
- bbox_valid high exactly one cycle: the cycle after the edge at which vsync is first sampled low; outputs valid in that same cycle and held until the next REPORT.
- Accumulator update latency 1 cycle after the pixel is sampled; a final pixel one cycle before vsync fall is included.
- Reset mid-frame: FSM to IDLE, accumulators and outputs cleared; frame lost, no bbox_valid.

## Configuration
- EDGE_BBOX_BORDER_MASK_EN defined: pixels with x=0, x=IMG_WIDTH-1, y=0 or y=IMG_HEIGHT-1 are never counted (suppresses Sobel window border artefacts). Undefined: all in-range pixels counted.

## Test plan
- IMG 8x4, single edge at (3,2), no mask → bbox_valid one cycle after vsync fall; x_min=x_max=3, y_min=y_max=2, edge_cnt=1, bbox_found=0 (MIN_EDGE_CNT=16).
- IMG 8x4, all pixels edge, MIN_EDGE_CNT=4 → edge_cnt=32, box (0,0)-(7,3), found=1; with mask → edge_cnt=12, box (1,1)-(6,2).
- Empty frame (sobel=0 throughout) → all coordinates 0, edge_cnt=0, bbox_found=0, bbox_valid still pulses.
- Line with 10 valid pixels at IMG_WIDTH=8, edges at x=8,9 only → edge_cnt=0; extra lines beyond IMG_HEIGHT ignored likewise.
- Release reset with vsync high, edges present → no bbox_valid at its fall; next full frame reports correctly.
- Assert rst_p mid-frame for 1 cycle → outputs 0 immediately (async), no strobe for that frame, next frame correct.
